// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: stage and mode encodings,
// the per-stage duration table and the stage/actuator helper functions.
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } stage_e;

    typedef enum logic [1:0] {
        MODE_SPIN   = 2'b00,
        MODE_SMALL  = 2'b01,
        MODE_MEDIUM = 2'b10,
        MODE_LARGE  = 2'b11
    } mode_e;

    typedef struct packed {
        logic water_in;
        logic water_out;
        logic motor;
        logic motor_fast;
    } act_t;

    // Stage durations in seconds.
    localparam logic [7:0] FILL_S         = 8'd3;
    localparam logic [7:0] DRAIN_S        = 8'd3;
    localparam logic [7:0] RINSE_S        = 8'd4;
    localparam logic [7:0] SPIN_S         = 8'd5;
    localparam logic [7:0] WASH_SMALL_S   = 8'd6;
    localparam logic [7:0] WASH_MEDIUM_S  = 8'd9;
    localparam logic [7:0] WASH_LARGE_S   = 8'd12;

    // Stages in which the program can be frozen by pause or an open door.
    function automatic logic is_active(input stage_e st);
        logic r;
        case (st)
            ST_FILL, ST_WASH, ST_DRAIN, ST_RINSE, ST_SPIN: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    // Actuator enables a stage asserts when it is not frozen.
    function automatic act_t stage_actuators(input stage_e st);
        act_t a;
        a = '0;
        case (st)
            ST_FILL:           a.water_in  = 1'b1;
            ST_WASH, ST_RINSE: a.motor     = 1'b1;
            ST_DRAIN:          a.water_out = 1'b1;
            ST_SPIN: begin
                a.water_out  = 1'b1;
                a.motor      = 1'b1;
                a.motor_fast = 1'b1;
            end
            default:           a = '0;
        endcase
        return a;
    endfunction

    // Wash length depends on the load size latched at start.
    function automatic logic [7:0] wash_secs(input mode_e m);
        logic [7:0] r;
        case (m)
            MODE_MEDIUM: r = WASH_MEDIUM_S;
            MODE_LARGE:  r = WASH_LARGE_S;
            default:     r = WASH_SMALL_S;
        endcase
        return r;
    endfunction

    // Seconds loaded into remain_s when a stage is entered.
    function automatic logic [7:0] stage_secs(input stage_e st, input mode_e m,
                                              input logic [7:0] done_s);
        logic [7:0] r;
        case (st)
            ST_FILL:  r = FILL_S;
            ST_WASH:  r = wash_secs(m);
            ST_DRAIN: r = DRAIN_S;
            ST_RINSE: r = RINSE_S;
            ST_SPIN:  r = SPIN_S;
            ST_DONE:  r = done_s;
            default:  r = 8'd0;
        endcase
        return r;
    endfunction

    // Stage that follows when the current one runs out of time.
    // pass distinguishes the wash half from the rinse half of a program.
    function automatic stage_e next_stage(input stage_e st, input logic pass,
                                          input logic aborting);
        stage_e r;
        case (st)
            ST_FILL:           r = pass ? ST_RINSE : ST_WASH;
            ST_WASH, ST_RINSE: r = ST_DRAIN;
            ST_DRAIN:          r = aborting ? ST_IDLE : (pass ? ST_SPIN : ST_FILL);
            ST_SPIN:           r = ST_DONE;
            default:           r = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap.
// clr forces the count to zero so a fresh second starts on the next cycle;
// en low holds the count.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Prescaler count register with clear priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer. Walks FILL/WASH/DRAIN/FILL/RINSE/DRAIN/
// SPIN/DONE (or SPIN/DONE for spin-only) on one-second ticks, freezes on
// pause or open door, and turns an abort into a draining exit to IDLE.
// Every output comes straight from a register; the stage output doubles as
// the FSM state for observation.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DONE_S   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       pause,
    input  logic       door_open,
    input  logic [1:0] mode,
    output logic       water_in,
    output logic       water_out,
    output logic       motor,
    output logic       motor_fast,
    output logic [2:0] stage,
    output logic [7:0] remain_s,
    output logic       busy,
    output logic       done,
    output logic       alarm
);

    localparam logic [7:0] DONE_SECS = 8'(DONE_S);

    stage_e     stage_q, stage_d;
    logic [7:0] remain_q, remain_d;
    logic       pass_q, pass_d;
    logic       aborting_q, aborting_d;
    mode_e      mode_q, mode_d;

    logic       frozen;
    logic       enter_stage;
    logic       tick;

    act_t       act_n;
    logic       frozen_n;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (enter_stage | frozen),
        .en   (~frozen),
        .tick (tick)
    );

    // Next-state logic: stage walk, remaining seconds, pass/abort flags.
    always_comb begin
        stage_d     = stage_q;
        remain_d    = remain_q;
        pass_d      = pass_q;
        aborting_d  = aborting_q;
        mode_d      = mode_q;
        enter_stage = 1'b0;
        frozen      = is_active(stage_q) && (pause || door_open);

        case (stage_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort; a door left open blocks it.
                if (start && !door_open) begin
                    mode_d      = mode_e'(mode);
                    pass_d      = 1'b0;
                    aborting_d  = 1'b0;
                    enter_stage = 1'b1;
                    stage_d     = (mode_e'(mode) == MODE_SPIN) ? ST_SPIN : ST_FILL;
                    remain_d    = stage_secs(stage_d, mode_e'(mode), DONE_SECS);
                end
            end
            ST_DONE: begin
                if (tick) begin
                    if (remain_q == 8'd1) begin
                        stage_d     = ST_IDLE;
                        remain_d    = 8'd0;
                        pass_d      = 1'b0;
                        aborting_d  = 1'b0;
                        enter_stage = 1'b1;
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    // Abort beats a coincident tick; an existing drain keeps its time.
                    aborting_d = 1'b1;
                    if (stage_q != ST_DRAIN) begin
                        stage_d     = ST_DRAIN;
                        remain_d    = DRAIN_S;
                        enter_stage = 1'b1;
                    end
                end else if (!frozen && tick) begin
                    if (remain_q == 8'd1) begin
                        stage_d     = next_stage(stage_q, pass_q, aborting_q);
                        remain_d    = stage_secs(stage_d, mode_q, DONE_SECS);
                        enter_stage = 1'b1;
                        if (stage_q == ST_DRAIN && !aborting_q && !pass_q) begin
                            pass_d = 1'b1;
                        end
                        if (stage_d == ST_IDLE) begin
                            pass_d     = 1'b0;
                            aborting_d = 1'b0;
                        end
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end
            end
        endcase
    end

    // Output decode from the upcoming stage, gated by the sensors seen now.
    always_comb begin
        act_n    = stage_actuators(stage_d);
        frozen_n = is_active(stage_d) && (pause || door_open);
        if (frozen_n) begin
            act_n = '0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q    <= ST_IDLE;
            remain_q   <= 8'd0;
            pass_q     <= 1'b0;
            aborting_q <= 1'b0;
            mode_q     <= MODE_SPIN;
        end else begin
            stage_q    <= stage_d;
            remain_q   <= remain_d;
            pass_q     <= pass_d;
            aborting_q <= aborting_d;
            mode_q     <= mode_d;
        end
    end

    // Registered actuator and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            water_in   <= 1'b0;
            water_out  <= 1'b0;
            motor      <= 1'b0;
            motor_fast <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            water_in   <= act_n.water_in;
            water_out  <= act_n.water_out;
            motor      <= act_n.motor;
            motor_fast <= act_n.motor_fast;
            busy       <= (stage_d != ST_IDLE);
            done       <= (stage_d == ST_DONE);
            alarm      <= door_open && is_active(stage_d);
        end
    end

    assign stage    = stage_q;
    assign remain_s = remain_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer with a four-cycle second. A reference model
// holds the program as a list of (stage, seconds) segments plus the number
// of clock cycles left in the current stage; each driven cycle pushes the
// expected outputs, and a monitor pops and compares after every clock edge.
module tb_wash_sequencer;

    localparam int TD = 4;
    localparam int DS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       pause = 1'b0;
    logic       door_open = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       water_in, water_out, motor, motor_fast;
    logic [2:0] stage;
    logic [7:0] remain_s;
    logic       busy, done, alarm;

    wash_sequencer #(
        .TICK_DIV (TD),
        .DONE_S   (DS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .pause      (pause),
        .door_open  (door_open),
        .mode       (mode),
        .water_in   (water_in),
        .water_out  (water_out),
        .motor      (motor),
        .motor_fast (motor_fast),
        .stage      (stage),
        .remain_s   (remain_s),
        .busy       (busy),
        .done       (done),
        .alarm      (alarm)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [17:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          count_en = 1'b0;
    int          busy_cyc = 0;
    int          win_cyc = 0;
    int          done_cyc = 0;
    int          seq_q[$];
    logic [2:0]  last_stage = 3'd0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int st;
        int sec;
    } seg_t;

    seg_t plan_q[$];
    int   m_stage = 0;
    int   m_cyc = 0;

    function automatic int secs_left();
        return (m_cyc + TD - 1) / TD;
    endfunction

    task automatic add_seg(input int st, input int sec);
        seg_t s;
        s.st  = st;
        s.sec = sec;
        plan_q.push_back(s);
    endtask

    // Program for a load size: two fill/drain halves, then spin and done.
    task automatic build_plan(input int m);
        plan_q.delete();
        if (m != 0) begin
            add_seg(1, 3);
            add_seg(2, 3 + 3 * m);
            add_seg(3, 3);
            add_seg(1, 3);
            add_seg(4, 4);
            add_seg(3, 3);
        end
        add_seg(5, 5);
        add_seg(6, DS);
    endtask

    task automatic enter_next();
        seg_t s;
        if (plan_q.size() == 0) begin
            m_stage = 0;
            m_cyc   = 0;
        end else begin
            s       = plan_q.pop_front();
            m_stage = s.st;
            m_cyc   = s.sec * TD;
        end
    endtask

    // Advance the model across one clock edge using the inputs now driven.
    task automatic model_step();
        bit active, frz, g, wi, wo, mo, mf, al;
        active = (m_stage >= 1 && m_stage <= 5);
        frz    = active && (pause || door_open);
        if (rst) begin
            m_stage = 0;
            m_cyc   = 0;
            plan_q.delete();
        end else if (m_stage == 0) begin
            if (start && !door_open) begin
                build_plan(int'(mode));
                enter_next();
            end
        end else if (abort && active) begin
            plan_q.delete();
            if (m_stage == 3) begin
                // The second boundary would have been crossed, but abort swallows it.
                if (frz || (m_cyc % TD) == 1) m_cyc = secs_left() * TD;
                else m_cyc = m_cyc - 1;
            end else begin
                m_stage = 3;
                m_cyc   = 3 * TD;
            end
        end else if (frz) begin
            m_cyc = secs_left() * TD;
        end else if (m_stage != 0) begin
            m_cyc = m_cyc - 1;
            if (m_cyc == 0) enter_next();
        end
        g  = (m_stage >= 1 && m_stage <= 5) && (pause || door_open);
        wi = (m_stage == 1) && !g;
        wo = (m_stage == 3 || m_stage == 5) && !g;
        mo = (m_stage == 2 || m_stage == 4 || m_stage == 5) && !g;
        mf = (m_stage == 5) && !g;
        al = door_open && (m_stage >= 1 && m_stage <= 5);
        exp_q.push_back({3'(m_stage), 8'(secs_left()), wi, wo, mo, mf,
                         (m_stage != 0), (m_stage == 6), al});
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [17:0] e;
        logic [17:0] a;
        forever begin
            @(posedge clk);
            #1;
            a = {stage, remain_s, water_in, water_out, motor, motor_fast, busy, done, alarm};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got stage=%0d remain=%0d wi/wo/m/mf=%b busy/done/alarm=%b expected stage=%0d remain=%0d wi/wo/m/mf=%b busy/done/alarm=%b",
                             $time, a[17:15], a[14:7], a[6:3], a[2:0],
                             e[17:15], e[14:7], e[6:3], e[2:0]);
                end
            end
            if (count_en) begin
                busy_cyc += int'(busy);
                win_cyc  += int'(water_in);
                done_cyc += int'(done);
                if (stage != last_stage) seq_q.push_back(int'(stage));
            end
            last_stage = stage;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input int m);
        mode  = 2'(m);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic run_idle(input int budget, input string tag, output int n);
        n = 0;
        while ((stage != 3'd0 || m_stage != 0) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reach_idle"}, int'(stage), 0);
    endtask

    task automatic run_to(input int st, input int rem, input int budget, input string tag);
        int n;
        n = 0;
        while (!(m_stage == st && secs_left() == rem) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_reach_stage"}, int'(stage), st);
    endtask

    task automatic clear_window();
        busy_cyc = 0;
        win_cyc  = 0;
        done_cyc = 0;
        seq_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int n;
        int exp_seq[9];
        exp_seq = '{1, 2, 3, 1, 4, 3, 5, 6, 0};

        rst = 1'b1;
        quiet(3);
        rst = 1'b0;
        quiet(3);

        // Small load, undisturbed: full walk, busy time, fill time.
        clear_window();
        count_en = 1'b1;
        do_start(1);
        run_idle(200, "mode01", n);
        quiet(2);
        count_en = 1'b0;
        check("mode01_busy_cycles", busy_cyc, 29 * TD);
        check("mode01_water_in_cycles", win_cyc, 6 * TD);
        check("mode01_done_cycles", done_cyc, DS * TD);
        check("mode01_seq_len", seq_q.size(), 9);
        for (int i = 0; i < 9 && i < seq_q.size(); i++) check("mode01_seq", seq_q[i], exp_seq[i]);

        // Spin-only program.
        clear_window();
        count_en = 1'b1;
        do_start(0);
        run_idle(100, "mode00", n);
        count_en = 1'b0;
        check("mode00_busy_cycles", busy_cyc, (5 + DS) * TD);

        // Large load, pause mid-wash at 7 s left.
        do_start(3);
        run_to(2, 7, 200, "pause_wash");
        pause = 1'b1;
        quiet(10);
        check("pause_remain_held", int'(remain_s), 7);
        check("pause_motor_off", int'(motor), 0);
        pause = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (stage == 3'd2 && n < 60);
        check("pause_wash_tail_cycles", n, 7 * TD);
        run_idle(300, "mode11", n);

        // Door open in IDLE blocks start; door open in SPIN freezes.
        door_open = 1'b1;
        do_start(2);
        quiet(3);
        check("door_idle_stage", int'(stage), 0);
        door_open = 1'b0;
        quiet(2);
        do_start(0);
        run_to(5, 3, 100, "door_spin");
        door_open = 1'b1;
        quiet(8);
        check("door_spin_alarm", int'(alarm), 1);
        check("door_spin_remain", int'(remain_s), 3);
        door_open = 1'b0;
        run_idle(100, "door_spin", n);

        // Abort mid-wash on a medium load.
        clear_window();
        count_en = 1'b1;
        do_start(2);
        run_to(2, 5, 200, "abort_wash");
        do_abort();
        check("abort_stage", int'(stage), 3);
        check("abort_water_out", int'(water_out), 1);
        run_idle(60, "abort", n);
        check("abort_drain_cycles", n, 3 * TD);
        quiet(2);
        count_en = 1'b0;
        check("abort_done_cycles", done_cyc, 0);

        // Asynchronous reset in the middle of rinse, then a fresh run.
        do_start(1);
        run_to(4, 2, 300, "rst_rinse");
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              int'({stage, remain_s, water_in, water_out, motor, motor_fast, busy, done, alarm}), 0);
        step();
        step();
        rst = 1'b0;
        quiet(2);
        clear_window();
        count_en = 1'b1;
        do_start(1);
        run_idle(200, "after_reset", n);
        quiet(1);
        count_en = 1'b0;
        check("after_reset_busy_cycles", busy_cyc, 29 * TD);
        check("after_reset_first_stage", (seq_q.size() > 0) ? seq_q[0] : -1, 1);

        // Randomized runs: sporadic pause/door/abort/extra starts, mode wiggling.
        for (int r = 0; r < 8; r++) begin
            do_start(int'($urandom_range(0, 3)));
            n = 0;
            while (m_stage != 0 && n < 800) begin
                start = ($urandom_range(0, 49) == 0);
                abort = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 19) == 0) pause = ~pause;
                if ($urandom_range(0, 29) == 0) door_open = ~door_open;
                mode = 2'($urandom_range(0, 3));
                step();
                start = 1'b0;
                abort = 1'b0;
                n++;
            end
            pause     = 1'b0;
            door_open = 1'b0;
            run_idle(300, "random", n);
            quiet(3);
        end

        quiet(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per 1-second tick.
REQ-002 Parameter DONE_S, default 2, seconds the DONE state is held.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse, begins a program.
REQ-007 abort  in  1  single-cycle pulse, cancels a running program.
REQ-008 pause  in  1  level, freezes the program while high.
REQ-009 door_open  in  1  level, door sensor.
REQ-010 mode  in  2  00 spin-only, 01 small, 10 medium, 11 large.
REQ-011 water_in / water_out / motor / motor_fast  out  1 each  actuator enables.
REQ-012 stage  out  3  IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6.
REQ-013 remain_s  out  8  seconds left in the current stage.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  high only in DONE.
REQ-016 alarm  out  1  high while door_open=1 in any state other than IDLE or DONE.

Function
REQ-017 Free-running prescaler counts 0..TICK_DIV-1; tick pulses for one cycle on the wrap.
REQ-018 Stage durations in seconds: FILL 3, WASH 6/9/12 for mode 01/10/11, DRAIN 3, RINSE 4, SPIN 5, DONE DONE_S.
REQ-019 On stage entry, remain_s loads that stage's duration and the prescaler clears to 0.
REQ-020 On a tick while not frozen: if remain_s==1, advance to the next stage; otherwise decrement remain_s.
REQ-021 In IDLE, start is accepted only when door_open=0; mode is latched on acceptance and ignored for the rest of the run.
REQ-022 For mode 00, an accepted start goes directly to SPIN; for other modes it goes to FILL with pass=0.
REQ-023 Sequence: FILL goes to WASH if pass=0, else RINSE; WASH and RINSE go to DRAIN.
REQ-024 DRAIN with pass=0 sets pass=1 and goes to FILL; DRAIN with pass=1 goes to SPIN.
REQ-025 SPIN goes to DONE; DONE goes to IDLE.
REQ-026 Actuators: FILL asserts water_in; WASH and RINSE assert motor; DRAIN asserts water_out; SPIN asserts water_out, motor and motor_fast; all other states assert none.
REQ-027 Frozen = (pause | door_open) in FILL, WASH, RINSE, DRAIN or SPIN.
REQ-028 While frozen: all actuators 0, remain_s held, prescaler held at 0, and stage unchanged.
REQ-029 On unfreeze, the current second restarts with a full TICK_DIV cycles.
REQ-030 abort in FILL, WASH, RINSE or SPIN: enter DRAIN with the aborting flag set.
REQ-031 abort while already in DRAIN: set the aborting flag and keep the current remain_s.
REQ-032 abort in IDLE or DONE is ignored.
REQ-033 DRAIN with aborting set goes to IDLE instead of following REQ-024.
REQ-034 Drain during abort is still subject to freezing.
REQ-035 If abort and tick occur in the same cycle, abort wins.
REQ-036 start while busy is ignored.
REQ-037 If start and abort occur in the same cycle in IDLE, start is taken.

Reset
REQ-038 rst forces: stage=IDLE, all actuators 0, remain_s=0, busy=0, done=0, alarm=0, pass=0, aborting=0, prescaler=0, latched mode=00.
REQ-039 Reset mid-run discards the program; there is no resume after reset.

Structure
REQ-040 Stage encodings, mode encodings and the duration table go in shared package wash_pkg.
REQ-041 The prescaler is sub-module tick_gen (parameter TICK_DIV; ports clk, rst, clr, en, tick).
REQ-042 All outputs are registered.

Verification (bench TICK_DIV=4)
REQ-043 mode=01, start, no disturbances: stage walks 1,2,3,1,4,3,5,6,0; busy for 29 s = 116 cycles; water_in high for exactly 6 s total.
REQ-044 mode=00, start: SPIN for 5 s with water_out=motor=motor_fast=1, then DONE for 2 s, then IDLE.
REQ-045 mode=11, pause high for 10 cycles during WASH with remain_s=7: actuators 0, remain_s stays 7; WASH ends 28 cycles after pause falls.
REQ-046 door_open=1 at IDLE with start pulse: stay IDLE. door_open raised during SPIN: alarm=1, motor=0, remain_s frozen.
REQ-047 abort during WASH of mode 10: next cycle stage=DRAIN with water_out=1; after 3 s stage=IDLE, done never asserted.
REQ-048 rst pulse mid-RINSE: all outputs return to reset values asynchronously; a fresh start then runs the full sequence from FILL.
